axi_crossbar_decerr_resp: RTL

Per-slave-interface responder for crossbar requests that failed address decode or admission security checks. It consumes the decode-error read and write commands issued by the slave-side address decoder. For reads it generates a full-length R burst with DECERR; for writes it sinks the W burst and then returns a single DECERR B beat. Read and write paths are independent and can run concurrently; it sits beside the response mux of each crossbar slave interface.

---
 rtl/axi_crossbar_decerr_resp_if.sv | 47 ++++
 rtl/axi_crossbar_decerr_resp.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_crossbar_decerr_resp_if.sv
// Signal bundle for the decode-error responder: the decoder's command channels
// plus the R, W and B channels the responder sources or sinks.
interface axi_crossbar_decerr_resp_if #(
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   s_rc_id;
    logic [7:0]            s_rc_len;
    logic                  s_rc_valid;
    logic                  s_rc_ready;

    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    logic [ID_WIDTH-1:0]   s_wc_id;
    logic                  s_wc_valid;
    logic                  s_wc_ready;

    logic                  s_axi_wlast;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;

    logic [ID_WIDTH-1:0]   m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    // Responder side.
    modport slave (
        input  s_rc_id, s_rc_len, s_rc_valid, m_axi_rready,
        input  s_wc_id, s_wc_valid, s_axi_wlast, s_axi_wvalid, m_axi_bready,
        output s_rc_ready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output s_wc_ready, s_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
    );

    // Decoder / crossbar side.
    modport master (
        output s_rc_id, s_rc_len, s_rc_valid, m_axi_rready,
        output s_wc_id, s_wc_valid, s_axi_wlast, s_axi_wvalid, m_axi_bready,
        input  s_rc_ready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  s_wc_ready, s_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
    );
endinterface

// File: rtl/axi_crossbar_decerr_resp.sv
// Answers crossbar requests that failed decode/security checks: full-length DECERR R bursts
// for reads, W-burst sink plus one DECERR B beat for writes. The two paths are independent.
module axi_crossbar_decerr_resp #(
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [1:0]  RESP_DECERR = 2'b11
) (
    input logic                       clk,
    input logic                       rst_n,
    axi_crossbar_decerr_resp_if.slave bus
);

    localparam logic       R_IDLE  = 1'b0;
    localparam logic       R_BURST = 1'b1;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DRAIN = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic                r_rd_state;
    logic                w_rd_state_nxt;
    logic                r_rc_ready;
    logic                w_rc_ready_nxt;
    logic                r_rvalid;
    logic                w_rvalid_nxt;
    logic                r_rlast;
    logic                w_rlast_nxt;
    logic [ID_WIDTH-1:0] r_rid;
    logic [ID_WIDTH-1:0] w_rid_nxt;
    logic [7:0]          r_rcnt;
    logic [7:0]          w_rcnt_nxt;

    logic                w_rc_fire;
    logic                w_r_fire;

    assign w_rc_fire = r_rc_ready & bus.s_rc_valid;
    assign w_r_fire  = r_rvalid & bus.m_axi_rready;

    // r_rcnt holds the beats still to go after the current one, so rlast is cnt==0.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rc_ready_nxt = r_rc_ready;
        w_rvalid_nxt   = r_rvalid;
        w_rlast_nxt    = r_rlast;
        w_rid_nxt      = r_rid;
        w_rcnt_nxt     = r_rcnt;
        case (r_rd_state)
            R_IDLE: begin
                w_rc_ready_nxt = 1'b1;
                if (w_rc_fire) begin
                    w_rd_state_nxt = R_BURST;
                    w_rc_ready_nxt = 1'b0;
                    w_rvalid_nxt   = 1'b1;
                    w_rid_nxt      = bus.s_rc_id;
                    w_rcnt_nxt     = bus.s_rc_len;
                    w_rlast_nxt    = (bus.s_rc_len == 8'd0);
                end
            end
            R_BURST: begin
                if (w_r_fire) begin
                    if (r_rcnt == 8'd0) begin
                        w_rd_state_nxt = R_IDLE;
                        w_rvalid_nxt   = 1'b0;
                        w_rlast_nxt    = 1'b0;
                        w_rc_ready_nxt = 1'b1;
                    end else begin
                        w_rcnt_nxt  = r_rcnt - 8'd1;
                        w_rlast_nxt = (r_rcnt == 8'd1);
                    end
                end
            end
            default: begin
                w_rd_state_nxt = R_IDLE;
                w_rvalid_nxt   = 1'b0;
                w_rlast_nxt    = 1'b0;
                w_rc_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= R_IDLE;
            r_rc_ready <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rid      <= '0;
            r_rcnt     <= 8'd0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rc_ready <= w_rc_ready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rlast    <= w_rlast_nxt;
            r_rid      <= w_rid_nxt;
            r_rcnt     <= w_rcnt_nxt;
        end
    end

    assign bus.s_rc_ready   = r_rc_ready;
    assign bus.m_axi_rid    = r_rid;
    assign bus.m_axi_rdata  = {DATA_WIDTH{1'b0}};
    assign bus.m_axi_rresp  = RESP_DECERR;
    assign bus.m_axi_rlast  = r_rlast;
    assign bus.m_axi_rvalid = r_rvalid;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic [1:0]          r_wr_state;
    logic [1:0]          w_wr_state_nxt;
    logic                r_wc_ready;
    logic                w_wc_ready_nxt;
    logic                r_wready;
    logic                w_wready_nxt;
    logic                r_bvalid;
    logic                w_bvalid_nxt;
    logic [ID_WIDTH-1:0] r_bid;
    logic [ID_WIDTH-1:0] w_bid_nxt;

    logic                w_wc_fire;
    logic                w_w_fire;
    logic                w_b_fire;

    assign w_wc_fire = r_wc_ready & bus.s_wc_valid;
    assign w_w_fire  = r_wready & bus.s_axi_wvalid;
    assign w_b_fire  = r_bvalid & bus.m_axi_bready;

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wc_ready_nxt = r_wc_ready;
        w_wready_nxt   = r_wready;
        w_bvalid_nxt   = r_bvalid;
        w_bid_nxt      = r_bid;
        case (r_wr_state)
            W_IDLE: begin
                w_wc_ready_nxt = 1'b1;
                if (w_wc_fire) begin
                    w_wr_state_nxt = W_DRAIN;
                    w_wc_ready_nxt = 1'b0;
                    w_wready_nxt   = 1'b1;
                    w_bid_nxt      = bus.s_wc_id;
                end
            end
            W_DRAIN: begin
                // Data is dropped; only wlast matters.
                if (w_w_fire && bus.s_axi_wlast) begin
                    w_wr_state_nxt = W_RESP;
                    w_wready_nxt   = 1'b0;
                    w_bvalid_nxt   = 1'b1;
                end
            end
            W_RESP: begin
                if (w_b_fire) begin
                    w_wr_state_nxt = W_IDLE;
                    w_bvalid_nxt   = 1'b0;
                    w_wc_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_wr_state_nxt = W_IDLE;
                w_wc_ready_nxt = 1'b0;
                w_wready_nxt   = 1'b0;
                w_bvalid_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
            r_wc_ready <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wc_ready <= w_wc_ready_nxt;
            r_wready   <= w_wready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bid      <= w_bid_nxt;
        end
    end

    assign bus.s_wc_ready   = r_wc_ready;
    assign bus.s_axi_wready = r_wready;
    assign bus.m_axi_bid    = r_bid;
    assign bus.m_axi_bresp  = RESP_DECERR;
    assign bus.m_axi_bvalid = r_bvalid;

    // ------------------------------------------------------------------
    // Protocol invariants
    // ------------------------------------------------------------------
    a_rlast_has_valid : assert property (@(posedge clk) disable iff (!rst_n)
        r_rlast |-> r_rvalid);
    a_r_stable_stall : assert property (@(posedge clk) disable iff (!rst_n)
        (r_rvalid && !bus.m_axi_rready) |=> (r_rvalid && $stable(r_rid) && $stable(r_rlast)));
    a_rc_ready_idle : assert property (@(posedge clk) disable iff (!rst_n)
        r_rc_ready |-> !r_rvalid);
    a_w_b_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !(r_wready && r_bvalid));
    a_wc_ready_idle : assert property (@(posedge clk) disable iff (!rst_n)
        r_wc_ready |-> !(r_wready || r_bvalid));

endmodule
